iic_write_master: RTL and testbench
===================================

# iic_write_master

Byte-level I2C (IIC) write master that executes one register-write transaction per request from the camera init sequencer. It latches the slave address, one or two register address bytes and one data byte, then generates START, the address/data bytes with ACK slots, and STOP on an open-drain SCL/SDA pair. It reports activity on `o_iic_busy`, whose falling edge tells the sequencer the write is done.

## Interface
- `CLK_DIV`, 125: clock cycles per SCL quarter-period. SCL period is 4*CLK_DIV; 100 kHz at 50 MHz. Minimum 3.
- `i_clk` in 1: system clock.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_iic_mode` in 1: 1 = two register address bytes (`h` then `l`); 0 = one byte (`l` only).
- `i_slave_addr` in 8: 8-bit slave address; bit0 is forced to 0 (write).
- `i_reg_addr_h` in 8: register address high byte.
- `i_reg_addr_l` in 8: register address low byte.
- `i_data_w` in 8: data byte.
- `i_iic_write` in 1: request, level pulse of any width ≥1; rising edge is significant.
- `i_sda` in 1: SDA pad input.
- `o_scl` out 1: SCL level; push-pull or open-drain at top.
- `o_sda_oe` out 1: 1 = pull SDA low; 0 = release.
- `o_iic_busy` out 1: transaction in progress.
- `o_nack` out 1: sticky; last transaction saw a NACK.

## Operation
- Reset values: `o_scl`=1, `o_sda_oe`=0, `o_iic_busy`=0, `o_nack`=0; FSM in IDLE; all counters 0.
- FSM states:
  - IDLE → START on a detected `i_iic_write` rising edge (registered previous value, compared each cycle).
  - START → BYTE → ACK → (BYTE … | STOP) → IDLE.
- Accepting a request:
  - Inputs are latched on the detect cycle; input changes afterwards have no effect.
  - `o_nack` clears on accept.
- Byte order:
  - mode 1: slave_addr&0xFE, reg_addr_h, reg_addr_l, data_w (4 bytes).
  - mode 0: slave_addr&0xFE, reg_addr_l, data_w (3 bytes).
  - Bits are sent MSB first.
- Every bit slot is 4 quarters of CLK_DIV cycles each:
  - SCL low in q0–q1, high in q2–q3.
  - `o_sda_oe` is updated at the first cycle of q0 and held for the whole slot.
- START: q0–q1 SCL high, SDA released; q2–q3 SCL high, SDA low.
- ACK slot:
  - SDA released.
  - `i_sda` passes through a 2-flop synchronizer.
  - The synchronized value is sampled on the last cycle of q3. 1 = NACK.
- STOP: q0 SCL low, SDA low; q1 SCL high, SDA low; q2–q3 SCL high, SDA released.
- Request handling outside IDLE:
  - Requests are only detected in IDLE.
  - A rising edge while busy, or in the same cycle busy falls, is dropped. It is not queued.
  - A trigger held high across the whole transaction produces exactly one transaction.

## Timing
- Request rising edge at cycle N (first cycle `i_iic_write`=1): detect registers at N+1; `o_iic_busy`=1 from N+1.
- SCL/SDA START activity begins at N+1.
- Transaction length, from busy rise to busy fall:
  - mode 1: 152*CLK_DIV cycles (4 + 4×36 + 4 quarters).
  - mode 0: 116*CLK_DIV cycles.
- `o_iic_busy` falls on the clock after the last STOP cycle. `o_scl`=1 and `o_sda_oe`=0 at that point.
- `o_nack` goes high in the cycle after the failing ACK sample.
- Reset asserted mid-transaction:
  - All outputs return to reset values asynchronously. No STOP is generated.
  - After release, the block waits in IDLE for a fresh rising edge. A trigger already high at release is not a rising edge.

## Configuration
- `IIC_ACK_CHECK_EN` defined:
  - A NACK in any ACK slot sets `o_nack` and jumps directly to STOP after that slot.
  - The remaining bytes are skipped; busy spans only the executed slots plus STOP.
- `IIC_ACK_CHECK_EN` undefined:
  - ACK slots are still clocked (SDA released), but `i_sda` is ignored.
  - All bytes are always sent; `o_nack` is tied 0.

## Test plan
- Mode 1, CLK_DIV=4, ACKing slave model, bytes 0x6C/0x30/0x34/0x0A:
  - Decoded SCL/SDA shows START, 6C-A, 30-A, 34-A, 0A-A, STOP.
  - `o_iic_busy` high exactly 608 cycles; `o_nack`=0.
- Mode 0, same stimulus: bytes 6C, 34, 0A only; busy high exactly 464 cycles.
- Slave NACKs the address byte, with `IIC_ACK_CHECK_EN`:
  - `o_nack`=1; STOP immediately follows the first ACK slot.
  - Busy high 44*CLK_DIV=176 cycles.
  - Next accepted request clears `o_nack`.
- Trigger held high 10 cycles, then a second pulse mid-transaction:
  - Exactly one transaction occurs.
  - The second pulse produces no extra busy period.
- Reset asserted during the second byte:
  - `o_scl`=1, `o_sda_oe`=0, `o_iic_busy`=0 in the same cycle.
  - A new request after release produces a full, correct transaction.
- Slave address 0x6D: first byte on the wire is 0x6C (R/W bit forced 0).

Source files
------------

// File: rtl/iic_write_master.sv
// Byte-level I2C write master: START, slave address (W), 1 or 2 register address bytes, data, STOP.
// Optional macro IIC_ACK_CHECK_EN: samples ACK slots and aborts to STOP on a NACK.
module iic_write_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_iic_mode,
    input  logic [7:0] i_slave_addr,
    input  logic [7:0] i_reg_addr_h,
    input  logic [7:0] i_reg_addr_l,
    input  logic [7:0] i_data_w,
    input  logic       i_iic_write,
    input  logic       i_sda,
    output logic       o_scl,
    output logic       o_sda_oe,
    output logic       o_iic_busy,
    output logic       o_nack
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_ACK, S_STOP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_quarter;
    logic [2:0]       r_bit;
    logic [1:0]       r_byte;
    logic             r_trig_d;
    logic             r_mode;
    logic [7:0]       r_reg_h;
    logic [7:0]       r_reg_l;
    logic [7:0]       r_data;
    logic [7:0]       r_shift;
    logic [7:0]       w_next_byte;
    logic             w_rise;
    logic             w_accept;
    logic             w_qend;
    logic             w_slot_end;
    logic             w_last_byte;
    logic             w_ack_fail;

    assign w_rise      = i_iic_write & ~r_trig_d;
    assign w_accept    = (r_state == S_IDLE) & w_rise;
    assign w_qend      = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_slot_end  = w_qend & (r_quarter == 2'd3);
    assign w_last_byte = r_mode ? (r_byte == 2'd3) : (r_byte == 2'd2);

    always_comb begin
        w_next_byte = r_data;
        if (r_mode) begin
            case (r_byte)
                2'd0:    w_next_byte = r_reg_h;
                2'd1:    w_next_byte = r_reg_l;
                default: w_next_byte = r_data;
            endcase
        end else if (r_byte == 2'd0) begin
            w_next_byte = r_reg_l;
        end
    end

`ifdef IIC_ACK_CHECK_EN
    logic r_sda_s1;
    logic r_sda_s2;
    logic r_nack;

    // Synchronizer idles at 1 (released bus) so a reset never fakes an ACK
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_nack   <= 1'b0;
        end else begin
            r_sda_s1 <= i_sda;
            r_sda_s2 <= r_sda_s1;
            if (w_accept)
                r_nack <= 1'b0;
            else if (w_ack_fail)
                r_nack <= 1'b1;
        end
    end

    assign w_ack_fail = (r_state == S_ACK) & w_slot_end & r_sda_s2;
    assign o_nack     = r_nack;
`else
    logic w_unused_sda;
    assign w_unused_sda = i_sda;
    assign w_ack_fail   = 1'b0;
    assign o_nack       = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        o_scl      = 1'b1;
        o_sda_oe   = 1'b0;
        o_iic_busy = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_iic_busy = 1'b0;
                if (w_rise)
                    w_next = S_START;
            end
            S_START: begin
                o_sda_oe = r_quarter[1];
                if (w_slot_end)
                    w_next = S_BYTE;
            end
            S_BYTE: begin
                o_scl    = r_quarter[1];
                o_sda_oe = ~r_shift[7];
                if (w_slot_end && (r_bit == 3'd7))
                    w_next = S_ACK;
            end
            S_ACK: begin
                o_scl = r_quarter[1];
                if (w_slot_end)
                    w_next = (w_ack_fail || w_last_byte) ? S_STOP : S_BYTE;
            end
            S_STOP: begin
                o_scl    = (r_quarter != 2'd0);
                o_sda_oe = ~r_quarter[1];
                if (w_slot_end)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Previous-trigger flop resets to 1 so a trigger already high at release is not an edge
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div     <= '0;
            r_quarter <= 2'd0;
            r_bit     <= 3'd0;
            r_byte    <= 2'd0;
            r_trig_d  <= 1'b1;
        end else begin
            r_trig_d <= i_iic_write;
            if (r_state == S_IDLE) begin
                r_div     <= '0;
                r_quarter <= 2'd0;
                r_bit     <= 3'd0;
                r_byte    <= 2'd0;
            end else begin
                r_div <= w_qend ? '0 : r_div + 1'b1;
                if (w_qend)
                    r_quarter <= r_quarter + 1'b1;
                if (w_slot_end && (r_state == S_BYTE))
                    r_bit <= r_bit + 1'b1;
                if (w_slot_end && (r_state == S_ACK))
                    r_byte <= r_byte + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mode  <= i_iic_mode;
            r_reg_h <= i_reg_addr_h;
            r_reg_l <= i_reg_addr_l;
            r_data  <= i_data_w;
            r_shift <= {i_slave_addr[7:1], 1'b0};
        end else if (w_slot_end && (r_state == S_BYTE)) begin
            r_shift <= {r_shift[6:0], 1'b0};
        end else if (w_slot_end && (r_state == S_ACK)) begin
            r_shift <= w_next_byte;
        end
    end

endmodule

// File: tb/tb_iic_write_master.sv
// Directed bench for iic_write_master with an ACKing slave model and an SCL/SDA bus decoder.
module tb_iic_write_master;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_iic_mode = 1'b0;
    logic [7:0] i_slave_addr = 8'h00;
    logic [7:0] i_reg_addr_h = 8'h00;
    logic [7:0] i_reg_addr_l = 8'h00;
    logic [7:0] i_data_w = 8'h00;
    logic       i_iic_write = 1'b0;
    logic       i_sda;
    logic       o_scl;
    logic       o_sda_oe;
    logic       o_iic_busy;
    logic       o_nack;

    int n_tests = 0;
    int n_fail  = 0;

    iic_write_master #(.CLK_DIV(CLK_DIV)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_iic_mode   (i_iic_mode),
        .i_slave_addr (i_slave_addr),
        .i_reg_addr_h (i_reg_addr_h),
        .i_reg_addr_l (i_reg_addr_l),
        .i_data_w     (i_data_w),
        .i_iic_write  (i_iic_write),
        .i_sda        (i_sda),
        .o_scl        (o_scl),
        .o_sda_oe     (o_sda_oe),
        .o_iic_busy   (o_iic_busy),
        .o_nack       (o_nack)
    );

    always #5 clk = ~clk;

    // Slave model and bus decoder, sampled on the falling clock edge
    logic       slave_pull = 1'b0;
    int         nack_idx = -1;
    logic [7:0] seen [8];
    logic [7:0] ack_bits = 8'h00;
    logic [7:0] sh = 8'h00;
    int         nbytes = 0;
    int         bitcnt = 0;
    int         n_starts = 0;
    int         n_stops = 0;
    int         busy_rises = 0;
    logic       prev_scl = 1'b1;
    logic       prev_line = 1'b1;
    logic       prev_busy = 1'b0;

    assign i_sda = ~(o_sda_oe | slave_pull);

    always @(negedge clk) begin
        logic lv;
        lv = ~(o_sda_oe | slave_pull);
        if (o_scl && prev_scl && prev_line && !lv) begin
            n_starts++;
            bitcnt = 0;
            nbytes = 0;
            slave_pull = 1'b0;
        end else if (o_scl && prev_scl && !prev_line && lv) begin
            n_stops++;
        end else if (o_scl && !prev_scl) begin
            if (bitcnt < 8) begin
                sh = {sh[6:0], lv};
                bitcnt++;
                if (bitcnt == 8 && nbytes < 8) seen[nbytes] = sh;
            end else begin
                if (nbytes < 8) ack_bits[nbytes] = lv;
                nbytes++;
                bitcnt = 0;
            end
        end else if (!o_scl && prev_scl) begin
            slave_pull = (bitcnt == 8) && (nbytes != nack_idx);
        end
        prev_scl  = o_scl;
        prev_line = lv;
        if (o_iic_busy && !prev_busy) busy_rises++;
        prev_busy = o_iic_busy;
    end

    task automatic clear_dec();
        n_starts = 0;
        n_stops  = 0;
        nbytes   = 0;
        bitcnt   = 0;
        ack_bits = 8'h00;
        for (int i = 0; i < 8; i++) seen[i] = 8'h00;
    endtask

    // Issue one request (trigger high for 'hold' cycles, optional extra pulse) and count busy cycles
    task automatic run_txn(input logic mode, input logic [7:0] sa, input logic [7:0] h,
                           input logic [7:0] l, input logic [7:0] d, input int hold,
                           input int pulse_at, output int cycles);
        int cnt;
        i_iic_mode   = mode;
        i_slave_addr = sa;
        i_reg_addr_h = h;
        i_reg_addr_l = l;
        i_data_w     = d;
        i_iic_write  = 1'b1;
        @(posedge clk); #1;
        i_slave_addr = ~sa;
        i_reg_addr_h = ~h;
        i_reg_addr_l = ~l;
        i_data_w     = ~d;
        i_iic_mode   = ~mode;
        cnt = 0;
        while (o_iic_busy && cnt < 2000) begin
            cnt++;
            if (cnt == hold) i_iic_write = 1'b0;
            if (pulse_at > 0 && cnt == pulse_at) i_iic_write = 1'b1;
            if (pulse_at > 0 && cnt == pulse_at + 2) i_iic_write = 1'b0;
            @(posedge clk); #1;
        end
        i_iic_write = 1'b0;
        if (cnt >= 2000) begin
            $display("FAIL busy_timeout: busy still high after %0d cycles, required to fall", cnt);
            cycles = -1;
        end else begin
            cycles = cnt;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        i_iic_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (o_scl !== 1'b1) begin n_fail++; $display("FAIL rst_scl: got %b want 1", o_scl); end
        n_tests++; if (o_sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_sda_oe: got %b want 0", o_sda_oe); end
        n_tests++; if (o_iic_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_iic_busy); end
        n_tests++; if (o_nack !== 1'b0) begin n_fail++; $display("FAIL rst_nack: got %b want 0", o_nack); end
        i_rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_tests++; if (o_iic_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_rst: busy got %b want 0", o_iic_busy); end
    endtask

    task automatic test_mode1();
        int len;
        clear_dec();
        nack_idx = -1;
        run_txn(1'b1, 8'h6C, 8'h30, 8'h34, 8'h0A, 1, 0, len);
        n_tests++; if (len !== 608) begin n_fail++; $display("FAIL m1_busy_len: got %0d want 608", len); end
        n_tests++; if (nbytes !== 4) begin n_fail++; $display("FAIL m1_nbytes: got %0d want 4", nbytes); end
        n_tests++; if ({seen[0], seen[1], seen[2], seen[3]} !== 32'h6C30340A) begin
            n_fail++; $display("FAIL m1_bytes: got %h want 6c30340a", {seen[0], seen[1], seen[2], seen[3]}); end
        n_tests++; if (ack_bits[3:0] !== 4'b0000) begin n_fail++; $display("FAIL m1_acks: got %b want 0000", ack_bits[3:0]); end
        n_tests++; if ({n_starts, n_stops} !== {32'd1, 32'd1}) begin
            n_fail++; $display("FAIL m1_start_stop: got %0d/%0d want 1/1", n_starts, n_stops); end
        n_tests++; if (o_nack !== 1'b0) begin n_fail++; $display("FAIL m1_nack: got %b want 0", o_nack); end
    endtask

    task automatic test_mode0();
        int len;
        clear_dec();
        nack_idx = -1;
        run_txn(1'b0, 8'h6C, 8'h30, 8'h34, 8'h0A, 1, 0, len);
        n_tests++; if (len !== 464) begin n_fail++; $display("FAIL m0_busy_len: got %0d want 464", len); end
        n_tests++; if (nbytes !== 3) begin n_fail++; $display("FAIL m0_nbytes: got %0d want 3", nbytes); end
        n_tests++; if ({seen[0], seen[1], seen[2]} !== 24'h6C340A) begin
            n_fail++; $display("FAIL m0_bytes: got %h want 6c340a", {seen[0], seen[1], seen[2]}); end
        n_tests++; if (n_stops !== 1) begin n_fail++; $display("FAIL m0_stop: got %0d want 1", n_stops); end
    endtask

    task automatic test_rw_bit();
        int len;
        clear_dec();
        nack_idx = -1;
        run_txn(1'b0, 8'h6D, 8'h00, 8'h12, 8'h55, 1, 0, len);
        n_tests++; if (seen[0] !== 8'h6C) begin n_fail++; $display("FAIL rw_bit: got %h want 6c", seen[0]); end
        n_tests++; if ({seen[1], seen[2]} !== 16'h1255) begin
            n_fail++; $display("FAIL rw_rest: got %h want 1255", {seen[1], seen[2]}); end
    endtask

    task automatic test_nack();
        int len;
        int exp_len;
        int exp_nb;
        logic exp_nack;
`ifdef IIC_ACK_CHECK_EN
        exp_len = 176; exp_nb = 1; exp_nack = 1'b1;
`else
        exp_len = 608; exp_nb = 4; exp_nack = 1'b0;
`endif
        clear_dec();
        nack_idx = 0;
        run_txn(1'b1, 8'h6C, 8'h30, 8'h34, 8'h0A, 1, 0, len);
        n_tests++; if (len !== exp_len) begin n_fail++; $display("FAIL nack_busy_len: got %0d want %0d", len, exp_len); end
        n_tests++; if (o_nack !== exp_nack) begin n_fail++; $display("FAIL nack_flag: got %b want %b", o_nack, exp_nack); end
        n_tests++; if (nbytes !== exp_nb) begin n_fail++; $display("FAIL nack_nbytes: got %0d want %0d", nbytes, exp_nb); end
        n_tests++; if (ack_bits[0] !== 1'b1) begin n_fail++; $display("FAIL nack_slot: got %b want 1", ack_bits[0]); end
        n_tests++; if (n_stops !== 1) begin n_fail++; $display("FAIL nack_stop: got %0d want 1", n_stops); end
        clear_dec();
        nack_idx = -1;
        run_txn(1'b1, 8'h6C, 8'h30, 8'h34, 8'h0A, 1, 0, len);
        n_tests++; if (o_nack !== 1'b0) begin n_fail++; $display("FAIL nack_clear: got %b want 0", o_nack); end
        n_tests++; if (len !== 608) begin n_fail++; $display("FAIL nack_next_len: got %0d want 608", len); end
    endtask

    task automatic test_back_to_back();
        int len;
        int rises0;
        clear_dec();
        nack_idx = -1;
        rises0 = busy_rises;
        run_txn(1'b1, 8'h6C, 8'h30, 8'h34, 8'h0A, 10, 200, len);
        repeat (30) @(posedge clk);
        #1;
        n_tests++; if (len !== 608) begin n_fail++; $display("FAIL b2b_len: got %0d want 608", len); end
        n_tests++; if (busy_rises - rises0 !== 1) begin
            n_fail++; $display("FAIL b2b_rises: got %0d want 1", busy_rises - rises0); end
        rises0 = busy_rises;
        run_txn(1'b0, 8'h6C, 8'h30, 8'h34, 8'h0A, 5000, 0, len);
        repeat (30) @(posedge clk);
        #1;
        n_tests++; if (len !== 464) begin n_fail++; $display("FAIL held_len: got %0d want 464", len); end
        n_tests++; if (busy_rises - rises0 !== 1) begin
            n_fail++; $display("FAIL held_rises: got %0d want 1", busy_rises - rises0); end
    endtask

    task automatic test_reset_mid();
        int len;
        int k;
        clear_dec();
        nack_idx = -1;
        i_iic_mode   = 1'b1;
        i_slave_addr = 8'h6C;
        i_reg_addr_h = 8'h30;
        i_reg_addr_l = 8'h34;
        i_data_w     = 8'h0A;
        i_iic_write  = 1'b1;
        @(posedge clk); #1;
        i_iic_write = 1'b0;
        k = 0;
        while (nbytes < 1 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        n_tests++; if (k >= 2000) begin n_fail++; $display("FAIL rmid_first_byte: waited %0d cycles, no byte", k); end
        repeat (20) @(posedge clk);
        #2;
        i_rst = 1'b0;
        #1;
        n_tests++; if (o_scl !== 1'b1) begin n_fail++; $display("FAIL rmid_scl: got %b want 1", o_scl); end
        n_tests++; if (o_sda_oe !== 1'b0) begin n_fail++; $display("FAIL rmid_sda_oe: got %b want 0", o_sda_oe); end
        n_tests++; if (o_iic_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", o_iic_busy); end
        i_iic_write = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_tests++; if (o_iic_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_held_trig: busy got %b want 0", o_iic_busy); end
        i_iic_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_dec();
        run_txn(1'b1, 8'h6C, 8'h30, 8'h34, 8'h0A, 1, 0, len);
        n_tests++; if (len !== 608) begin n_fail++; $display("FAIL rmid_len: got %0d want 608", len); end
        n_tests++; if ({seen[0], seen[1], seen[2], seen[3]} !== 32'h6C30340A) begin
            n_fail++; $display("FAIL rmid_bytes: got %h want 6c30340a", {seen[0], seen[1], seen[2], seen[3]}); end
    endtask

    initial begin
        test_reset();
        test_mode1();
        test_mode0();
        test_rw_bit();
        test_nack();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
